// File: rtl/ysyx_23060061_wb_arbiter_pkg.sv
// Shared definitions for the GPR write-back arbiter.
//   WB_ADDR_W  : default GPR index width
//   WB_DATA_W  : default GPR data width
//   WB_QDEPTH  : default per-source queue depth
//   wb_entry_t : one queued write-back result {rd, data}
package ysyx_23060061_wb_arbiter_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_QDEPTH = 2;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_23060061_wb_arbiter_if.sv
// Bus bundle between the result producers / decode (master) and the write-back arbiter (slave).
//   exu_*     : EXU result valid/ready channel
//   lsu_*     : LSU load result valid/ready channel
//   iss_*     : decode issue marking a destination busy
//   chk_*     : decode hazard query and its combinational stall answer
//   gpr_*     : registered GPR file write port
interface ysyx_23060061_wb_arbiter_if
    import ysyx_23060061_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
    parameter int unsigned DATA_WIDTH = WB_DATA_W
);
    logic                  exu_valid;
    logic                  exu_ready;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic [ADDR_WIDTH-1:0] chk_rs1;
    logic [ADDR_WIDTH-1:0] chk_rs2;
    logic [ADDR_WIDTH-1:0] chk_rd;
    logic                  chk_stall;
    logic                  gpr_wen;
    logic [ADDR_WIDTH-1:0] gpr_waddr;
    logic [DATA_WIDTH-1:0] gpr_wdata;

    modport master (
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
        input  exu_ready, lsu_ready, chk_stall,
        input  gpr_wen, gpr_waddr, gpr_wdata
    );

    modport slave (
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
        output exu_ready, lsu_ready, chk_stall,
        output gpr_wen, gpr_waddr, gpr_wdata
    );

endinterface

// File: rtl/ysyx_23060061_wb_fifo.sv
// Small synchronous FIFO holding results from one producer.
//   clk, rst  : clock, synchronous active-high reset (empties the queue)
//   in_valid  : producer has an entry; accepted when in_ready is also high
//   in_ready  : queue not full and not in reset
//   in_data   : entry to push
//   pop       : consumer takes the head entry this cycle (ignored when empty)
//   empty     : queue holds no entries
//   head      : oldest entry, valid while !empty
module ysyx_23060061_wb_fifo
    import ysyx_23060061_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_QDEPTH,
    parameter type         T     = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    input  logic pop,
    output logic empty,
    output T     head
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop_ok;

    // Ready looks only at the registered count: a same-cycle pop never frees a slot early.
    always_comb begin
        empty    = (count == '0);
        in_ready = !rst && (count != CW'(DEPTH));
        push     = in_valid && in_ready;
        pop_ok   = pop && !empty;
        head     = mem[rd_ptr];
    end

    // Pointers wrap naturally since DEPTH is a power of two; count separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Storage needs no reset; only the count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/ysyx_23060061_wb_arbiter.sv
// GPR write-back arbiter: queues EXU and LSU results, grants one write per cycle
// (round-robin when both are pending, LSU first after reset), drives the registered
// GPR write port and keeps a per-register busy scoreboard for decode hazard stalls.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ysyx_23060061_wb_arbiter_if (producers, issue/check, GPR port)
module ysyx_23060061_wb_arbiter
    import ysyx_23060061_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
    parameter int unsigned DATA_WIDTH = WB_DATA_W,
    parameter int unsigned QDEPTH     = WB_QDEPTH
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_23060061_wb_arbiter_if.slave bus
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                exu_in, lsu_in, exu_head, lsu_head, win;
    logic                  exu_empty, lsu_empty;
    logic                  pop_exu, pop_lsu, contested;
    logic                  lsu_turn;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NREG-1:0]       busy_q, busy_d;

    always_comb begin
        exu_in.rd   = bus.exu_rd;
        exu_in.data = bus.exu_data;
        lsu_in.rd   = bus.lsu_rd;
        lsu_in.data = bus.lsu_data;
    end

    ysyx_23060061_wb_fifo #(.DEPTH(QDEPTH), .T(entry_t)) u_exu_q (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.exu_valid),
        .in_ready (bus.exu_ready),
        .in_data  (exu_in),
        .pop      (pop_exu),
        .empty    (exu_empty),
        .head     (exu_head)
    );

    ysyx_23060061_wb_fifo #(.DEPTH(QDEPTH), .T(entry_t)) u_lsu_q (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.lsu_valid),
        .in_ready (bus.lsu_ready),
        .in_data  (lsu_in),
        .pop      (pop_lsu),
        .empty    (lsu_empty),
        .head     (lsu_head)
    );

    // One pop per cycle; lsu_turn only matters when both queues hold entries.
    always_comb begin
        pop_exu   = 1'b0;
        pop_lsu   = 1'b0;
        contested = !exu_empty && !lsu_empty;
        if (contested) begin
            if (lsu_turn) pop_lsu = 1'b1;
            else          pop_exu = 1'b1;
        end else if (!lsu_empty) begin
            pop_lsu = 1'b1;
        end else if (!exu_empty) begin
            pop_exu = 1'b1;
        end
        win = pop_lsu ? lsu_head : exu_head;
    end

    // Round-robin pointer flips on every contested grant.
    always_ff @(posedge clk) begin
        if (rst)            lsu_turn <= 1'b1;
        else if (contested) lsu_turn <= !lsu_turn;
    end

    // GPR write port; x0 entries are consumed without raising the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= (pop_exu || pop_lsu) && (win.rd != '0);
            if (pop_exu || pop_lsu) begin
                waddr_q <= win.rd;
                wdata_q <= win.data;
            end
        end
    end

    // Busy clears on the edge the GPR file captures the write; a same-edge issue re-sets it.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) busy_d[waddr_q] = 1'b0;
        if (bus.iss_valid && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        bus.gpr_wen   = wen_q;
        bus.gpr_waddr = waddr_q;
        bus.gpr_wdata = wdata_q;
        bus.chk_stall = busy_q[bus.chk_rs1] | busy_q[bus.chk_rs2] | busy_q[bus.chk_rd];
    end

endmodule

// File: tb/tb_ysyx_23060061_wb_arbiter.sv
// Self-checking bench for the GPR write-back arbiter: directed scenarios plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_ysyx_23060061_wb_arbiter;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned QD = 2;
    localparam int unsigned NR = 32;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ment_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060061_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_23060061_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    ment_t         mq_e[$];
    ment_t         mq_l[$];
    ment_t         m_wlog[$];
    bit [NR-1:0]   m_busy   = '0;
    bit            m_lsu_turn = 1'b1;
    logic          m_wen    = 1'b0;
    logic [AW-1:0] m_waddr  = '0;
    logic [DW-1:0] m_wdata  = '0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit m_stall(logic [AW-1:0] a, logic [AW-1:0] b, logic [AW-1:0] c);
        return m_busy[a] | m_busy[b] | m_busy[c];
    endfunction

    function automatic bit m_rdy_e();
        return !rst && (mq_e.size() < QD);
    endfunction

    function automatic bit m_rdy_l();
        return !rst && (mq_l.size() < QD);
    endfunction

    task automatic idle_inputs();
        bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic step();
        ment_t pe;
        bit    popped;
        bit    push_e;
        bit    push_l;
        popped = 1'b0;
        pe = '{rd: '0, data: '0};
        if (rst) begin
            mq_e.delete(); mq_l.delete();
            m_busy = '0; m_lsu_turn = 1'b1;
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            push_e = bus.exu_valid && (mq_e.size() < QD);
            push_l = bus.lsu_valid && (mq_l.size() < QD);
            if (mq_e.size() > 0 && mq_l.size() > 0) begin
                pe = m_lsu_turn ? mq_l.pop_front() : mq_e.pop_front();
                m_lsu_turn = !m_lsu_turn;
                popped = 1'b1;
            end else if (mq_l.size() > 0) begin
                pe = mq_l.pop_front(); popped = 1'b1;
            end else if (mq_e.size() > 0) begin
                pe = mq_e.pop_front(); popped = 1'b1;
            end
            if (m_wen) m_busy[m_waddr] = 1'b0;
            if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
            m_wen = popped && (pe.rd != 0);
            if (popped) begin
                m_waddr = pe.rd;
                m_wdata = pe.data;
            end
            if (m_wen) m_wlog.push_back(pe);
            if (push_e) mq_e.push_back('{rd: bus.exu_rd, data: bus.exu_data});
            if (push_l) mq_l.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        n_checks++; if (bus.gpr_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b exp 0", bus.gpr_wen); end
        n_checks++; if (bus.gpr_waddr !== '0 || bus.gpr_wdata !== '0) begin n_fail++; $display("FAIL reset_addr_data got %0d/%h exp 0/0", bus.gpr_waddr, bus.gpr_wdata); end
        n_checks++; if (bus.exu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b exp 00", bus.exu_ready, bus.lsu_ready); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++; if (bus.gpr_wen !== 1'b0) begin n_fail++; $display("FAIL idle_wen cycle %0d got %b exp 0", c, bus.gpr_wen); end
            n_checks++; if (bus.exu_ready !== 1'b1 || bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready cycle %0d got %b%b exp 11", c, bus.exu_ready, bus.lsu_ready); end
        end
        for (int r = 0; r < NR; r++) begin
            bus.chk_rs1 = AW'(r); bus.chk_rs2 = AW'(r); bus.chk_rd = AW'(r);
            #1;
            n_checks++; if (bus.chk_stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall reg %0d got %b exp 0", r, bus.chk_stall); end
        end
        idle_inputs();
    endtask

    task automatic test_single_write();
        bus.chk_rs1 = 5'd5;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        step();
        bus.iss_valid = 1'b0;
        n_checks++; if (bus.chk_stall !== 1'b1) begin n_fail++; $display("FAIL single_stall_issue got %b exp 1", bus.chk_stall); end
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEADBEEF;
        step();
        bus.exu_valid = 1'b0;
        n_checks++; if (bus.gpr_wen !== 1'b0 || bus.chk_stall !== 1'b1) begin n_fail++; $display("FAIL single_push wen/stall got %b/%b exp 0/1", bus.gpr_wen, bus.chk_stall); end
        step();
        n_checks++; if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 5'd5 || bus.gpr_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write got %b/%0d/%h exp 1/5/deadbeef", bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata); end
        n_checks++; if (bus.chk_stall !== 1'b1) begin n_fail++; $display("FAIL single_stall_write got %b exp 1", bus.chk_stall); end
        step();
        n_checks++; if (bus.gpr_wen !== 1'b0 || bus.chk_stall !== 1'b0) begin n_fail++; $display("FAIL single_after wen/stall got %b/%b exp 0/0", bus.gpr_wen, bus.chk_stall); end
        idle_inputs();
    endtask

    task automatic test_alternate();
        ment_t dlog[$];
        int    ie, il, ne, nl, cyc, not_rdy;
        bit    pe, pl;
        ie = 0; il = 0; cyc = 0; not_rdy = 0;
        m_wlog.delete();
        while ((ie < 8 || il < 8 || mq_e.size() > 0 || mq_l.size() > 0 || m_wen) && cyc < 60) begin
            bus.exu_valid = (ie < 8); bus.exu_rd = AW'(ie + 1); bus.exu_data = 32'hE000_0000 | 32'(ie + 1);
            bus.lsu_valid = (il < 8); bus.lsu_rd = AW'(il + 1); bus.lsu_data = 32'h1000_0000 | 32'(il + 1);
            pe = bus.exu_valid && m_rdy_e();
            pl = bus.lsu_valid && m_rdy_l();
            step();
            cyc++;
            if (pe) ie++;
            if (pl) il++;
            if (bus.gpr_wen === 1'b1) dlog.push_back('{rd: bus.gpr_waddr, data: bus.gpr_wdata});
            if (!bus.exu_ready || !bus.lsu_ready) not_rdy++;
            n_checks++; if (bus.gpr_wen !== m_wen) begin n_fail++; $display("FAIL alt_wen cycle %0d got %b exp %b", cyc, bus.gpr_wen, m_wen); end
            n_checks++; if (bus.exu_ready !== m_rdy_e() || bus.lsu_ready !== m_rdy_l()) begin n_fail++; $display("FAIL alt_ready cycle %0d got %b%b exp %b%b", cyc, bus.exu_ready, bus.lsu_ready, m_rdy_e(), m_rdy_l()); end
        end
        idle_inputs();
        n_checks++; if (cyc >= 60) begin n_fail++; $display("FAIL alt_timeout cycles %0d limit 60", cyc); end
        n_checks++; if (not_rdy == 0) begin n_fail++; $display("FAIL alt_ready_drop got 0 not-ready cycles exp >0"); end
        n_checks++; if (dlog.size() != 16) begin n_fail++; $display("FAIL alt_count got %0d exp 16", dlog.size()); end
        ne = 0; nl = 0;
        for (int k = 0; k < dlog.size(); k++) begin
            // write k must come from LSU on even k, EXU on odd k, each source in rd order
            n_checks++;
            if ((k % 2) == 0) begin
                nl++;
                if (dlog[k].data !== (32'h1000_0000 | 32'(nl)) || dlog[k].rd !== AW'(nl)) begin n_fail++; $display("FAIL alt_order write %0d got %0d/%h exp %0d/%h", k, dlog[k].rd, dlog[k].data, nl, 32'h1000_0000 | 32'(nl)); end
            end else begin
                ne++;
                if (dlog[k].data !== (32'hE000_0000 | 32'(ne)) || dlog[k].rd !== AW'(ne)) begin n_fail++; $display("FAIL alt_order write %0d got %0d/%h exp %0d/%h", k, dlog[k].rd, dlog[k].data, ne, 32'hE000_0000 | 32'(ne)); end
            end
            if (k < m_wlog.size()) begin
                n_checks++; if (dlog[k].data !== m_wlog[k].data) begin n_fail++; $display("FAIL alt_model write %0d got %h exp %h", k, dlog[k].data, m_wlog[k].data); end
            end
        end
    endtask

    task automatic test_rd_zero();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        step();
        bus.iss_valid = 1'b0;
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'h0000_1234;
        step();
        bus.exu_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++; if (bus.gpr_wen !== 1'b0) begin n_fail++; $display("FAIL rd0_wen cycle %0d got %b exp 0", c, bus.gpr_wen); end
            bus.chk_rs1 = 5'd0; #1;
            n_checks++; if (bus.chk_stall !== 1'b0) begin n_fail++; $display("FAIL rd0_stall_x0 cycle %0d got %b exp 0", c, bus.chk_stall); end
            bus.chk_rs1 = 5'd9; #1;
            n_checks++; if (bus.chk_stall !== 1'b1) begin n_fail++; $display("FAIL rd0_busy9 cycle %0d got %b exp 1", c, bus.chk_stall); end
        end
        n_checks++; if (bus.exu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_drained got %b exp 1", bus.exu_ready); end
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h99;
        step();
        bus.exu_valid = 1'b0;
        step(); step();
        n_checks++; if (bus.chk_stall !== 1'b0) begin n_fail++; $display("FAIL rd0_clear9 got %b exp 0", bus.chk_stall); end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        bus.chk_rs1 = 5'd7;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        step();
        bus.iss_valid = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
        step();
        bus.lsu_valid = 1'b0;
        step();
        n_checks++; if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 5'd7) begin n_fail++; $display("FAIL setwin_write got %b/%0d exp 1/7", bus.gpr_wen, bus.gpr_waddr); end
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        step();
        bus.iss_valid = 1'b0;
        n_checks++; if (bus.chk_stall !== 1'b1) begin n_fail++; $display("FAIL setwin_busy got %b exp 1", bus.chk_stall); end
        step(); step();
        n_checks++; if (bus.chk_stall !== 1'b1) begin n_fail++; $display("FAIL setwin_hold got %b exp 1", bus.chk_stall); end
        bus.lsu_valid = 1'b1; bus.lsu_data = 32'h78;
        step();
        bus.lsu_valid = 1'b0;
        step(); step();
        n_checks++; if (bus.chk_stall !== 1'b0) begin n_fail++; $display("FAIL setwin_clear got %b exp 0", bus.chk_stall); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.chk_rs1 = 5'd3; bus.chk_rs2 = 5'd4;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; step();
        bus.iss_rd = 5'd4; step();
        bus.iss_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.exu_valid = 1'b1; bus.exu_rd = AW'(10 + c); bus.exu_data = 32'hA0 + 32'(c);
            bus.lsu_valid = 1'b1; bus.lsu_rd = AW'(20 + c); bus.lsu_data = 32'hB0 + 32'(c);
            step();
        end
        bus.exu_valid = 1'b0; bus.lsu_valid = 1'b0;
        n_checks++; if (bus.chk_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b exp 1", bus.chk_stall); end
        rst = 1'b1;
        step();
        n_checks++; if (bus.gpr_wen !== 1'b0 || bus.exu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_reset wen/rdy got %b/%b%b exp 0/00", bus.gpr_wen, bus.exu_ready, bus.lsu_ready); end
        n_checks++; if (bus.chk_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_cleared got %b exp 0", bus.chk_stall); end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++; if (bus.gpr_wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen cycle %0d got %b exp 0", c, bus.gpr_wen); end
        end
        n_checks++; if (bus.exu_ready !== 1'b1 || bus.lsu_ready !== 1'b1 || bus.chk_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_after rdy/stall got %b%b/%b exp 11/0", bus.exu_ready, bus.lsu_ready, bus.chk_stall); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit exp_stall;
        for (int c = 0; c < 400; c++) begin
            rst = (($urandom % 64) == 0);
            bus.exu_valid = $urandom % 2; bus.exu_rd = AW'($urandom); bus.exu_data = $urandom;
            bus.lsu_valid = $urandom % 2; bus.lsu_rd = AW'($urandom); bus.lsu_data = $urandom;
            bus.iss_valid = (($urandom % 4) == 0); bus.iss_rd = AW'($urandom);
            bus.chk_rs1 = AW'($urandom); bus.chk_rs2 = AW'($urandom); bus.chk_rd = AW'($urandom);
            step();
            exp_stall = m_stall(bus.chk_rs1, bus.chk_rs2, bus.chk_rd);
            n_checks++; if (bus.gpr_wen !== m_wen) begin n_fail++; $display("FAIL rand_wen cycle %0d got %b exp %b", c, bus.gpr_wen, m_wen); end
            if (m_wen) begin
                n_checks++; if (bus.gpr_waddr !== m_waddr || bus.gpr_wdata !== m_wdata) begin n_fail++; $display("FAIL rand_write cycle %0d got %0d/%h exp %0d/%h", c, bus.gpr_waddr, bus.gpr_wdata, m_waddr, m_wdata); end
            end
            n_checks++; if (bus.exu_ready !== m_rdy_e() || bus.lsu_ready !== m_rdy_l()) begin n_fail++; $display("FAIL rand_ready cycle %0d got %b%b exp %b%b", c, bus.exu_ready, bus.lsu_ready, m_rdy_e(), m_rdy_l()); end
            n_checks++; if (bus.chk_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall cycle %0d got %b exp %b", c, bus.chk_stall, exp_stall); end
        end
        rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < 6; c++) step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_alternate();
        test_rd_zero();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
